// File: rtl/pic_core.sv
// Programmable interrupt controller core: command-word programming, rotating
// fully-nested priority and a two-pulse interrupt acknowledge cycle.
module pic_core #(
    parameter int NUM_IRQ      = 8,
    parameter int SPURIOUS_IDX = NUM_IRQ - 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cs_n,
    input  logic               wr_n,
    input  logic               rd_n,
    input  logic               a0,
    input  logic [7:0]         din,
    output logic [7:0]         dout,
    output logic               dout_en,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               inta_n,
    output logic               int_out
);
    typedef enum logic [1:0] {S_UNINIT, S_ICW2, S_READY, S_ACK} state_t;
    typedef struct packed {
        logic       found;
        logic [2:0] ch;
    } hit_t;

    localparam logic [7:0] VALID   = 8'((1 << NUM_IRQ) - 1);
    localparam logic [2:0] LP_RST  = 3'(NUM_IRQ - 1);
    localparam logic [2:0] SPUR_CH = 3'(SPURIOUS_IDX);

    // Channel vectors are held 8 bits wide; bits at or above NUM_IRQ stay zero.
    state_t     state;
    logic [7:0] irr, isr, imr, base;
    logic [7:0] sync1, sync2, irq_prev;
    logic [2:0] lp, frozen;
    logic       level, rsel;
    logic       wr_idle_q, inta_hi_q, vec_active;

    logic [7:0] irq_ext, rise, ack_mask, irr_clr, rdata;
    logic [7:0] irr_d, isr_d, imr_d, base_d;
    logic [2:0] lp_d;
    logic       level_d, rsel_d;
    hit_t       top, eoi;
    logic       cand_ok, wr_act, wr_evt, rd_evt, ack_evt, ack1, ack2;
    logic       is_icw1, is_icw2, is_ocw1, is_ocw2, is_ocw3;

    function automatic hit_t find_hi(input logic [7:0] v, input logic [2:0] ptr);
        hit_t h;
        int   c;
        h = '0;
        // Scan from lowest to highest priority so the final hit is the winner.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            c = int'(ptr) + 1 + i;
            if (c >= NUM_IRQ) c -= NUM_IRQ;
            if (v[3'(c)]) h = '{found: 1'b1, ch: 3'(c)};
        end
        return h;
    endfunction

    assign irq_ext = 8'(irq_in);
    assign wr_act  = ~cs_n & ~wr_n;
    assign wr_evt  = wr_act & wr_idle_q;
    assign rd_evt  = ~cs_n & ~rd_n & wr_n;
    assign ack_evt = ~inta_n & inta_hi_q;
    assign ack1    = ack_evt && (state == S_READY);
    assign ack2    = ack_evt && (state == S_ACK);

    assign is_icw1 = wr_evt & ~a0 & din[4];
    assign is_ocw2 = wr_evt & ~a0 & (din[4:3] == 2'b00);
    assign is_ocw3 = wr_evt & ~a0 & (din[4:3] == 2'b01);
    assign is_icw2 = wr_evt & a0 & (state == S_ICW2);
    assign is_ocw1 = wr_evt & a0 & (state != S_ICW2);

    assign rdata = a0 ? imr : (rsel ? isr : irr);

    // A pending request wins only if it outranks every in-service channel.
    assign top     = find_hi((irr & ~imr) | isr, lp);
    assign cand_ok = top.found && !isr[top.ch];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        rise     = sync2 & ~irq_prev;
        ack_mask = (ack1 && cand_ok) ? (8'b1 << top.ch) : 8'h00;
        // NOTE: blocking assignments here model ordered combinational steps: acknowledge, then write.
        isr_d    = isr | ack_mask;
        irr_clr  = level ? 8'h00 : ack_mask;
        imr_d    = imr;
        base_d   = base;
        lp_d     = lp;
        level_d  = level;
        rsel_d   = rsel;
        eoi      = find_hi(isr_d, lp);

        if (is_ocw2) begin
            unique case (din[7:5])
                3'b001: if (eoi.found) isr_d[eoi.ch] = 1'b0;
                3'b011: isr_d[din[2:0]] = 1'b0;
                3'b101: if (eoi.found) begin
                    isr_d[eoi.ch] = 1'b0;
                    lp_d          = eoi.ch;
                end
                default: ;
            endcase
        end
        if (is_ocw3 && din[1]) rsel_d = din[0];
        if (is_ocw1) imr_d = din & VALID;
        if (is_icw2) base_d = din;
        if (is_icw1) begin
            level_d = din[3];
            imr_d   = 8'h00;
            isr_d   = 8'h00;
            irr_clr = 8'hff;
            lp_d    = LP_RST;
            rsel_d  = 1'b0;
        end
        // A new edge overrides a clear of the same bit in the same cycle.
        irr_d = level ? sync2 : ((irr & ~irr_clr) | rise);
    end

    // NOTE: sequential state uses non-blocking assignments; later ones in the block take priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_UNINIT;
            irr        <= '0;
            isr        <= '0;
            imr        <= '0;
            base       <= '0;
            lp         <= LP_RST;
            level      <= 1'b0;
            rsel       <= 1'b0;
            sync1      <= '0;
            sync2      <= '0;
            irq_prev   <= '0;
            frozen     <= '0;
            wr_idle_q  <= 1'b1;
            inta_hi_q  <= 1'b0;
            vec_active <= 1'b0;
            int_out    <= 1'b0;
            dout       <= '0;
            dout_en    <= 1'b0;
        end else begin
            sync1     <= irq_ext;
            sync2     <= sync1;
            irq_prev  <= sync2;
            wr_idle_q <= ~wr_act;
            inta_hi_q <= inta_n;
            irr       <= irr_d;
            isr       <= isr_d;
            imr       <= imr_d;
            base      <= base_d;
            lp        <= lp_d;
            level     <= level_d;
            rsel      <= rsel_d;

            if (ack1) begin
                state  <= S_ACK;
                frozen <= cand_ok ? top.ch : SPUR_CH;
            end else if (ack2) begin
                state <= S_READY;
            end
            if (is_icw1)      state <= S_ICW2;
            else if (is_icw2) state <= S_READY;

            int_out    <= (state == S_READY) && cand_ok && !ack1 && !is_icw1;
            vec_active <= ack2 || (vec_active && !inta_n);

            if (ack2) begin
                dout    <= base + {5'b0, frozen};
                dout_en <= 1'b1;
            end else if (vec_active && !inta_n) begin
                dout_en <= 1'b1;
            end else if (rd_evt) begin
                dout    <= rdata;
                dout_en <= 1'b1;
            end else begin
                dout    <= '0;
                dout_en <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pic_core.sv
// Scoreboarded bench for pic_core: directed scenarios plus randomized traffic
// against a priority-walk reference model.
module tb_pic_core;
    localparam int N    = 8;
    localparam int SPUR = N - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cs_n = 1'b1, wr_n = 1'b1, rd_n = 1'b1, a0 = 1'b0;
    logic [7:0]   din = 8'h00;
    logic [7:0]   dout;
    logic         dout_en;
    logic [N-1:0] irq_in = '0;
    logic         inta_n = 1'b1;
    logic         int_out;

    always #5 clk = ~clk;

    pic_core #(.NUM_IRQ(N), .SPURIOUS_IDX(SPUR)) dut (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .a0(a0),
        .din(din), .dout(dout), .dout_en(dout_en), .irq_in(irq_in),
        .inta_n(inta_n), .int_out(int_out)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: 0 UNINIT, 1 waiting for ICW2, 2 READY, 3 between acknowledges.
    int         m_state;
    logic [7:0] m_irr, m_isr, m_imr, m_base, m_lines;
    int         m_lp, m_frozen;
    bit         m_level, m_rsel;

    function automatic logic [7:0] m_req();
        return m_level ? m_lines : m_irr;
    endfunction

    // Walk channels in priority order; whichever of in-service or pending shows up first decides.
    function automatic int m_cand();
        logic [7:0] r;
        int ch;
        r = m_req();
        for (int i = 0; i < N; i++) begin
            ch = (m_lp + 1 + i) % N;
            if (m_isr[ch]) return -1;
            if (r[ch] && !m_imr[ch]) return ch;
        end
        return -1;
    endfunction

    function automatic int m_top_isr();
        int ch;
        for (int i = 0; i < N; i++) begin
            ch = (m_lp + 1 + i) % N;
            if (m_isr[ch]) return ch;
        end
        return -1;
    endfunction

    function automatic bit m_int();
        return (m_state == 2) && (m_cand() >= 0);
    endfunction

    task automatic model_reset();
        m_state = 0; m_irr = 0; m_isr = 0; m_imr = 0; m_base = 0; m_lines = 0;
        m_lp = N - 1; m_frozen = 0; m_level = 0; m_rsel = 0;
    endtask

    task automatic model_write(input bit a, input logic [7:0] d);
        int t;
        if (!a && d[4]) begin
            m_state = 1; m_level = d[3]; m_imr = 0; m_isr = 0; m_irr = 0;
            m_lp = N - 1; m_rsel = 0;
        end else if (!a && !d[3]) begin
            case (d[7:5])
                3'd1: begin t = m_top_isr(); if (t >= 0) m_isr[t] = 1'b0; end
                3'd3: m_isr[d[2:0]] = 1'b0;
                3'd5: begin t = m_top_isr(); if (t >= 0) begin m_isr[t] = 1'b0; m_lp = t; end end
                default: ;
            endcase
        end else if (!a) begin
            if (d[1]) m_rsel = d[0];
        end else if (m_state == 1) begin
            m_base = d; m_state = 2;
        end else begin
            m_imr = d;
        end
    endtask

    task automatic model_ack();
        int c;
        if (m_state == 2) begin
            c = m_cand();
            if (c >= 0) begin
                m_isr[c] = 1'b1;
                if (!m_level) m_irr[c] = 1'b0;
                m_frozen = c;
            end else begin
                m_frozen = SPUR;
            end
            m_state = 3;
        end else if (m_state == 3) begin
            exp_q.push_back(8'(int'(m_base) + m_frozen));
            m_state = 2;
        end
    endtask

    // Monitor: every fresh dout_en assertion is one response to be matched.
    bit prev_en = 1'b0;
    always @(negedge clk) begin
        if (dout_en && !prev_en) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_dout: got 0x%0h, expected no output", dout);
            end else begin
                check("dout", {24'h0, dout}, {24'h0, exp_q.pop_front()});
            end
        end
        prev_en = dout_en;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cpu_write(input bit a, input logic [7:0] d);
        @(negedge clk);
        cs_n = 1'b0; wr_n = 1'b0; a0 = a; din = d;
        @(negedge clk);
        cs_n = 1'b1; wr_n = 1'b1;
        model_write(a, d);
        idle(2);
    endtask

    task automatic cpu_read(input bit a);
        @(negedge clk);
        cs_n = 1'b0; rd_n = 1'b0; a0 = a;
        exp_q.push_back(a ? m_imr : (m_rsel ? m_isr : m_req()));
        @(negedge clk);
        cs_n = 1'b1; rd_n = 1'b1;
        idle(2);
    endtask

    // sel: 0 IRR, 1 ISR, 2 IMR
    task automatic read_reg(input int sel);
        if (sel < 2) cpu_write(1'b0, (sel == 1) ? 8'h0B : 8'h0A);
        cpu_read(sel == 2);
    endtask

    task automatic inta_pulse();
        @(negedge clk);
        inta_n = 1'b0;
        model_ack();
        @(negedge clk);
        @(negedge clk);
        inta_n = 1'b1;
        idle(2);
    endtask

    task automatic ack_pair();
        inta_pulse();
        inta_pulse();
    endtask

    task automatic pulse_irq(input logic [7:0] m);
        @(negedge clk);
        irq_in = m; m_lines = m;
        idle(4);
        irq_in = '0; m_lines = 8'h00;
        if (!m_level) m_irr = m_irr | m;
        idle(3);
    endtask

    task automatic check_int(input string name);
        check(name, {31'h0, int_out}, {31'h0, m_int()});
    endtask

    initial begin
        model_reset();
        idle(1);
        check("reset_int_out", {31'h0, int_out}, 32'h0);
        check("reset_dout_en", {31'h0, dout_en}, 32'h0);
        check("reset_dout", {24'h0, dout}, 32'h0);
        rst_n = 1'b1;
        idle(2);
        cpu_read(1'b0);
        cpu_read(1'b1);
        inta_pulse();
        check_int("uninit_int");

        // Basic vectoring and synchronizer latency
        cpu_write(1'b0, 8'h10);
        cpu_write(1'b1, 8'h40);
        @(negedge clk);
        irq_in[3] = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("latency_edge3", {31'h0, int_out}, 32'h0);
        @(posedge clk);
        #1 check("latency_edge4", {31'h0, int_out}, 32'h1);
        m_irr[3] = 1'b1;
        @(negedge clk);
        irq_in[3] = 1'b0;
        idle(2);
        ack_pair();
        read_reg(1);
        read_reg(0);
        check_int("after_ack3");

        // Fully nested: lower blocked, higher preempts
        pulse_irq(8'h20);
        check_int("irq5_blocked");
        pulse_irq(8'h02);
        check_int("irq1_preempts");
        ack_pair();
        read_reg(1);
        cpu_write(1'b0, 8'h20);
        check_int("eoi1_irq5_still_blocked");
        cpu_write(1'b0, 8'h20);
        check_int("eoi3_irq5_pending");
        ack_pair();
        cpu_write(1'b0, 8'h20);

        // Masking
        cpu_write(1'b1, 8'h04);
        pulse_irq(8'h04);
        check_int("masked_irq2");
        read_reg(0);
        read_reg(2);
        cpu_write(1'b1, 8'h00);
        check_int("unmasked_irq2");
        ack_pair();
        cpu_write(1'b0, 8'h20);

        // Rotate on EOI
        pulse_irq(8'h08);
        ack_pair();
        read_reg(1);
        cpu_write(1'b0, 8'hA0);
        read_reg(1);
        pulse_irq(8'h11);
        check_int("rotated_pending");
        ack_pair();
        cpu_write(1'b0, 8'h20);
        ack_pair();
        cpu_write(1'b0, 8'h20);
        check_int("rotated_done");

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            int op;
            op = $urandom_range(0, 5);
            case (op)
                0, 1: pulse_irq(8'($urandom_range(0, 255) & $urandom_range(0, 255)));
                2: cpu_write(1'b1, 8'($urandom_range(0, 255) & $urandom_range(0, 255)
                                     & $urandom_range(0, 255)));
                3: ack_pair();
                4: begin
                    int k;
                    k = $urandom_range(0, 3);
                    case (k)
                        0: cpu_write(1'b0, 8'h20);
                        1: cpu_write(1'b0, 8'h60 | 8'($urandom_range(0, 7)));
                        2: cpu_write(1'b0, 8'hA0);
                        default: cpu_write(1'b0, 8'h40);
                    endcase
                end
                default: read_reg($urandom_range(0, 2));
            endcase
            check_int("rand_int");
        end

        // Level mode and spurious acknowledge
        cpu_write(1'b0, 8'h18);
        cpu_write(1'b1, 8'h40);
        @(negedge clk);
        irq_in[6] = 1'b1; m_lines = 8'h40;
        idle(5);
        check_int("level_high");
        irq_in[6] = 1'b0; m_lines = 8'h00;
        idle(5);
        check_int("level_dropped");
        ack_pair();
        read_reg(1);
        irq_in[6] = 1'b1; m_lines = 8'h40;
        idle(5);
        ack_pair();
        read_reg(0);
        read_reg(1);
        irq_in[6] = 1'b0; m_lines = 8'h00;
        idle(5);
        cpu_write(1'b0, 8'h20);

        // Reset between acknowledge pulses
        cpu_write(1'b0, 8'h10);
        cpu_write(1'b1, 8'h40);
        pulse_irq(8'h08);
        check_int("pre_reset_int");
        @(negedge clk);
        inta_n = 1'b0;
        model_ack();
        @(negedge clk);
        inta_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midack_rst_int_out", {31'h0, int_out}, 32'h0);
        check("midack_rst_dout_en", {31'h0, dout_en}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        inta_n = 1'b0;
        model_ack();
        @(negedge clk);
        check("post_rst_no_vector_a", {31'h0, dout_en}, 32'h0);
        @(negedge clk);
        check("post_rst_no_vector_b", {31'h0, dout_en}, 32'h0);
        inta_n = 1'b1;
        idle(3);
        check_int("post_rst_int");

        check("scoreboard_drained", exp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pic_core.md
PIC_CORE -- requirements
Module: pic_core

Interface
REQ-001 Parameter NUM_IRQ, default 8, number of request channels, legal range 2..8.
REQ-002 Parameter SPURIOUS_IDX, default NUM_IRQ-1, channel index whose vector is returned on a spurious acknowledge.
REQ-003 Clock and reset are fixed: one clock; reset is asynchronous and active-low.
REQ-004 Port list, one per line, clock and reset first:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cs_n  in  1  chip select, active low, synchronous to clk.
- wr_n  in  1  write strobe, active low, synchronous to clk.
- rd_n  in  1  read strobe, active low, synchronous to clk.
- a0  in  1  register address bit.
- din  in  8  CPU write data.
- dout  out  8  CPU read data or interrupt vector.
- dout_en  out  1  dout valid/drive enable.
- irq_in  in  NUM_IRQ  asynchronous peripheral requests.
- inta_n  in  1  CPU interrupt acknowledge, active low, synchronous to clk.
- int_out  out  1  interrupt request to CPU.

Function
REQ-005 Write event: first cycle with cs_n=0 and wr_n=0 after a cycle where either was 1; acknowledge event: first cycle inta_n=0 after inta_n=1.
REQ-006 Decode: a0=0 & din[4]=1 -> ICW1; a0=0 & din[4:3]=00 -> OCW2; a0=0 & din[4:3]=01 -> OCW3; a0=1 -> ICW2 in state ICW2, otherwise OCW1.
REQ-007 States UNINIT, ICW2, READY, ACK; ICW1 from any state -> ICW2; ICW2 write -> READY; first acknowledge in READY -> ACK; second acknowledge in ACK -> READY.
REQ-008 ICW1 latches level mode = din[3], clears IMR, ISR, IRR, sets lowest-priority pointer to NUM_IRQ-1, read select to IRR, drops int_out.
REQ-009 ICW2 latches vector base = din; vector for channel k = base + k, modulo 256.
REQ-010 OCW1 writes IMR = din[NUM_IRQ-1:0]; masked channels never raise int_out but remain visible in IRR.
REQ-011 OCW2 din[7:5]: 001 clears highest-priority ISR bit; 011 clears ISR[din[2:0]]; 101 clears highest-priority ISR bit and sets lowest-priority pointer to that channel; other codes ignored; no ISR bit set -> no change.
REQ-012 OCW3 din[1:0]: 10 selects IRR, 11 selects ISR for reads; other values keep the selection.
REQ-013 Read (cs_n=0, rd_n=0, wr_n=1): dout = selected IRR/ISR (a0=0) or IMR (a0=1), zero-extended, dout_en=1 the cycle after; dout_en=0 otherwise except during vector drive.
REQ-014 irq_in passes a 2-flop synchronizer; edge mode sets IRR on a synchronized 0->1 transition; level mode IRR equals synchronized level.
REQ-015 Priority rotates: highest priority is channel (pointer+1) mod NUM_IRQ, descending cyclically; reset order IR0 highest.
REQ-016 Candidate = highest-priority bit of IRR & ~IMR strictly above highest-priority ISR bit (fully nested); int_out registered = candidate exists and state READY.
REQ-017 Latency: irq_in rising before edge 1, unmasked, no higher ISR -> IRR set after edge 3, int_out high after edge 4.
REQ-018 First acknowledge: freeze candidate, set its ISR bit, clear its IRR bit (edge mode), int_out=0 next cycle; no candidate -> freeze SPURIOUS_IDX, no ISR change.
REQ-019 Second acknowledge: dout = frozen vector, dout_en=1 while inta_n stays low, then 0.
REQ-020 Edge-mode IRR set and clear same cycle on same bit: set wins.
REQ-021 Write and acknowledge in same cycle: acknowledge processed first, then write.
REQ-022 Acknowledge in UNINIT or ICW2 ignored; writes in ACK other than ICW1 take effect without leaving ACK.

Reset
REQ-023 rst_n=0 forces immediately: state UNINIT, int_out=0, dout=0, dout_en=0, IRR=ISR=IMR=0, base=0, level mode=0, pointer=NUM_IRQ-1, read select IRR, synchronizers 0.
REQ-024 Reset mid-acknowledge abandons the cycle; no vector driven after release.

Verification
REQ-025 ICW1=0x10, ICW2=0x40, irq_in[3] rises -> int_out high 4 edges later; two INTA pulses -> dout=0x43, ISR=0x08, IRR=0x00.
REQ-026 ISR[3] set, irq_in[5] rises -> int_out stays 0; irq_in[1] rises -> int_out 1, vector 0x41, ISR=0x0A.
REQ-027 OCW1=0x04, irq_in[2] rises -> no int_out; OCW3=0x0A then read -> dout=0x04; OCW1=0x00 -> int_out rises.
REQ-028 ISR=0x08, OCW2=0xA0 -> ISR=0x00, pointer=3; irq_in[0] and irq_in[4] together -> vector 0x44 first.
REQ-029 Level mode (ICW1=0x18), irq_in[6] pulsed then dropped before INTA1 -> spurious vector 0x47, ISR unchanged.
REQ-030 rst_n asserted between INTA pulses -> int_out=0, dout_en=0, second pulse drives nothing.
